comb_pipe_reg: RTL and testbench
================================

COMB_PIPE_REG -- requirements
Module: comb_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of pipeline register stages (>=1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set offered.
REQ-006 SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port op  input  2  operation: 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-009 SHALL have port c  input  WIDTH  output gating mask, unregistered.
REQ-010 SHALL have port out_valid  output  1  final stage holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port q  output  WIDTH  registered result of final stage.
REQ-013 SHALL have port y  output  WIDTH  q & c, combinational.

Function
REQ-014 SHALL compute d = a op b as a combinational intermediate in the stage-0 clocked process; d SHALL NOT be a separate flop.
REQ-015 SHALL transfer in when in_valid && in_ready; d written to stage 0 with valid set.
REQ-016 SHALL implement stage k ready = !valid[k] || ready[k+1]; final-stage ready = !out_valid || out_ready; in_ready = ready[0].
REQ-017 SHALL advance stage k into k+1 when valid[k] && ready[k+1]; stage k valid clears if not refilled same cycle.
REQ-018 SHALL give latency DEPTH cycles from input transfer to out_valid with out_ready held 1, throughput one result per cycle.
REQ-019 SHALL hold stage data and valid unchanged while stalled; no result dropped or duplicated.
REQ-020 SHALL accept a new input in the same cycle as the final result is consumed when pipeline full.
REQ-021 SHALL keep q at last loaded value when out_valid=0 (data registers load only on transfer).
REQ-022 SHALL update y the same delta as c or q changes, independent of out_valid.
REQ-023 SHALL, for DEPTH=1, make stage 0 the output stage (in_ready = !out_valid || out_ready).

Reset
REQ-024 SHALL on rst_n=0 immediately clear all stage valids and data: out_valid=0, q=0, y=0, in_ready=1 after release.
REQ-025 SHALL discard in-flight results on reset mid-operation; first transfer after release sees empty pipeline.
REQ-026 SHALL take no input transfer in a cycle where rst_n is low at the clock edge.

Configuration
REQ-027 SHALL, with COMB_PIPE_STATS_EN defined, add output result_count (16 bit): increments on each out_valid && out_ready, saturates at 16'hFFFF, reset to 0.
REQ-028 SHALL, without COMB_PIPE_STATS_EN, have no result_count port and no counter logic.

Structure
REQ-029 SHALL place op encoding typedef (enum OP_AND, OP_OR, OP_XOR, OP_NAND) and the logic-op function in package comb_pipe_pkg.
REQ-030 SHALL implement one stage as sub-module comb_pipe_stage (valid/data register with ready chain), instantiated DEPTH-1 times via generate after stage 0.

Verification
REQ-031 SHALL test: rst_n low, release at t=2, a=b=8'hFF op=AND c=8'h0F in_valid=1 one cycle -> out_valid after 2 cycles, q=8'hFF, y=8'h0F.
REQ-032 SHALL test: back-to-back ops a=8'hF0 b=8'h3C with op 0..3 -> q sequence 30,FC,CC,CF on consecutive cycles.
REQ-033 SHALL test: out_ready=0 with 3 inputs offered, DEPTH=2 -> in_ready drops after 2 accepted; release gives results in order, none lost.
REQ-034 SHALL test: rst_n pulsed low with pipeline full -> out_valid=0, q=0 asynchronously; no old result appears afterwards.
REQ-035 SHALL test: DEPTH=1, full with out_ready=1 and in_valid=1 -> simultaneous consume and accept every cycle.
REQ-036 SHALL test: with COMB_PIPE_STATS_EN, 5 consumed results -> result_count=5; forced near 16'hFFFF saturates.

Source files
------------

// File: rtl/comb_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comb_pipe_pkg : op encoding and per-bit logic op for comb_pipe_reg    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package comb_pipe_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  function automatic logic pipe_op_bit(input op_e i_op, input logic i_a, input logic i_b);
    case (i_op)
      OP_AND:  pipe_op_bit = i_a & i_b;
      OP_OR:   pipe_op_bit = i_a | i_b;
      OP_XOR:  pipe_op_bit = i_a ^ i_b;
      default: pipe_op_bit = ~(i_a & i_b);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/comb_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comb_pipe_stage : one valid/data pipeline register with ready logic   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module comb_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic             i_dn_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_ready;

  assign w_ready = !r_valid || i_dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_ready) begin
      r_valid <= i_up_valid;
      if (i_up_valid) begin
        r_data <= i_up_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/comb_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comb_pipe_reg : logic op (a op b) through a DEPTH-stage valid/ready   |
// | pipeline, output gated by c. COMB_PIPE_STATS_EN adds result_count.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module comb_pipe_reg
  import comb_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] y
`ifdef COMB_PIPE_STATS_EN
  ,
  output logic [15:0]      result_count
`endif
);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_ready;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             r_valid0;
  logic [WIDTH-1:0] r_data0;

  // Unrolled form of ready[k] = !valid[k] || ready[k+1]; avoids a
  // combinational chain through one vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ready
    assign w_ready[k] = out_ready || !(&w_valid[DEPTH-1:k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid0 <= 1'b0;
      r_data0  <= '0;
    end else if (w_ready[0]) begin
      r_valid0 <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          r_data0[i] <= pipe_op_bit(op_e'(op), a[i], b[i]);
        end
      end
    end
  end

  assign w_valid[0] = r_valid0;
  assign w_data[0]  = r_data0;

  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    logic w_dn_ready;
    if (k == DEPTH - 1) begin : g_last
      assign w_dn_ready = out_ready;
    end else begin : g_mid
      assign w_dn_ready = w_ready[k+1];
    end
    comb_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_up_valid (w_valid[k-1]),
      .i_up_data  (w_data[k-1]),
      .i_dn_ready (w_dn_ready),
      .o_valid    (w_valid[k]),
      .o_data     (w_data[k])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[DEPTH-1];
  assign q         = w_data[DEPTH-1];
  assign y         = q & c;

`ifdef COMB_PIPE_STATS_EN
  logic [15:0] r_result_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_count <= 16'h0000;
    end else if (out_valid && out_ready && (r_result_count != 16'hFFFF)) begin
      r_result_count <= r_result_count + 16'h0001;
    end
  end

  assign result_count = r_result_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comb_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_comb_pipe_reg : directed bench for DEPTH=2 and DEPTH=1 instances   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_comb_pipe_reg;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] c;
    logic [7:0] eq;
    logic [7:0] ey;
  } vec_t;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, c, q, y;
  logic [1:0] op;
  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0] a1, b1, c1, q1, y1;
  logic [1:0] op1;
`ifdef COMB_PIPE_STATS_EN
  logic [15:0] result_count, result_count1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [N];

  always #5 clk = ~clk;

  comb_pipe_reg #(.WIDTH(8), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .y(y)
`ifdef COMB_PIPE_STATS_EN
    , .result_count(result_count)
`endif
  );

  comb_pipe_reg #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .op(op1), .c(c1), .out_valid(out_valid1), .out_ready(out_ready1),
    .q(q1), .y(y1)
`ifdef COMB_PIPE_STATS_EN
    , .result_count(result_count1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hF0, 8'h3C, 2'd0, 8'hFF, 8'h30, 8'h30};
    vecs[1] = '{8'hF0, 8'h3C, 2'd1, 8'h0F, 8'hFC, 8'h0C};
    vecs[2] = '{8'hF0, 8'h3C, 2'd2, 8'hF0, 8'hCC, 8'hC0};
    vecs[3] = '{8'hF0, 8'h3C, 2'd3, 8'hAA, 8'hCF, 8'h8A};
    vecs[4] = '{8'hAA, 8'h55, 2'd0, 8'hFF, 8'h00, 8'h00};
    vecs[5] = '{8'hAA, 8'h55, 2'd1, 8'h3C, 8'hFF, 8'h3C};
    vecs[6] = '{8'hAA, 8'h55, 2'd2, 8'h00, 8'hFF, 8'h00};
    vecs[7] = '{8'hAA, 8'hAA, 2'd3, 8'hFF, 8'h55, 8'h55};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; op = 2'd0; c = 8'h0F;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = 8'h00; b1 = 8'h00; op1 = 2'd0; c1 = 8'hFF;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst q", q, 0);
    check("rst y", y, 0);
    check("rst in_ready", in_ready, 1);
    check("rst1 out_valid", out_valid1, 0);
    #1;
    rst_n = 1'b1;

    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'd0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("first latency out_valid", out_valid, 0);
    @(negedge clk);
    check("first out_valid", out_valid, 1);
    check("first q", q, 8'hFF);
    check("first y", y, 8'h0F);
    tick();

    for (int j = 0; j <= N; j++) begin
      if (j < N) begin
        in_valid = 1'b1; a = vecs[j].a; b = vecs[j].b; op = vecs[j].op;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #2;
      if (j >= 1) c = vecs[j-1].c;
      #1;
      if (j == 0) begin
        check("vec latency out_valid", out_valid, 0);
      end else begin
        check($sformatf("vec%0d out_valid", j-1), out_valid, 1);
        check($sformatf("vec%0d q", j-1), q, vecs[j-1].eq);
        check($sformatf("vec%0d y", j-1), y, vecs[j-1].ey);
      end
    end
    @(posedge clk);
    #3;
    check("drain out_valid", out_valid, 0);
    check("hold q", q, vecs[N-1].eq);
    c = 8'hF0;
    #1;
    check("y follows c when idle", y, vecs[N-1].eq & 8'hF0);
    tick();

    out_ready = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h00; op = 2'd1; c = 8'hFF;
    #1; check("stall in_ready 0", in_ready, 1);
    tick();
    a = 8'h02;
    #1; check("stall in_ready 1", in_ready, 1);
    tick();
    a = 8'h03;
    #1;
    check("stall full in_ready", in_ready, 0);
    check("stall full out_valid", out_valid, 1);
    check("stall full q", q, 8'h01);
    tick(); tick();
    check("stall held q", q, 8'h01);
    check("stall held out_valid", out_valid, 1);
    check("stall held in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1; check("consume+accept in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("release q0", q, 8'h02);
    check("release v0", out_valid, 1);
    tick();
    check("release q1", q, 8'h03);
    check("release v1", out_valid, 1);
    tick();
    check("release empty", out_valid, 0);

    out_ready = 1'b0; in_valid = 1'b1; a = 8'h77; b = 8'h00; op = 2'd1;
    tick(); tick();
    check("pre-reset full", out_valid, 1);
    check("pre-reset q", q, 8'h77);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst q", q, 0);
    check("async rst y", y, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    tick(); tick(); tick();
    check("post-reset no stale", out_valid, 0);
    check("post-reset in_ready", in_ready, 1);
    in_valid = 1'b1; a = 8'h12; b = 8'h34; op = 2'd2;
    tick();
    in_valid = 1'b0;
    tick();
    check("post-reset xfer v", out_valid, 1);
    check("post-reset xfer q", q, 8'h26);

    for (int i = 0; i < 5; i++) begin
      in_valid1 = 1'b1; a1 = 8'h10 + 8'(i); b1 = 8'h00; op1 = 2'd1;
      #1; check($sformatf("d1 in_ready %0d", i), in_ready1, 1);
      tick();
      check($sformatf("d1 out_valid %0d", i), out_valid1, 1);
      check($sformatf("d1 q %0d", i), q1, 8'h10 + 8'(i));
    end
    in_valid1 = 1'b0;
    tick();
    check("d1 drained", out_valid1, 0);
`ifdef COMB_PIPE_STATS_EN
    check("result_count 5", result_count1, 16'd5);
`endif
    in_valid1 = 1'b1; a1 = 8'h5A; out_ready1 = 1'b0;
    tick();
    check("d1 stall in_ready", in_ready1, 0);
    check("d1 stall q", q1, 8'h5A);
    a1 = 8'h99;
    tick();
    check("d1 stall hold q", q1, 8'h5A);
    out_ready1 = 1'b1; in_valid1 = 1'b0;
    tick();
    check("d1 stall drained", out_valid1, 0);
    check("d1 last q", q1, 8'h5A);
`ifdef COMB_PIPE_STATS_EN
    force u_dut1.r_result_count = 16'hFFFE;
    #1;
    release u_dut1.r_result_count;
    in_valid1 = 1'b1; a1 = 8'h01;
    tick(); tick(); tick();
    in_valid1 = 1'b0;
    tick();
    check("result_count saturate", result_count1, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
